// File: rtl/endpoint_table_writer_if.sv
// Request/response channel between the control path (PS or ARP handler) and endpoint_table_writer.
interface endpoint_table_writer_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [31:0] req_ip;
    logic [47:0] req_dst_mac;
    logic [47:0] req_src_mac;
    logic        done;
    logic [1:0]  status;

    modport master (
        output req_valid, req_op, req_ip, req_dst_mac, req_src_mac,
        input  req_ready, done, status
    );

    modport slave (
        input  req_valid, req_op, req_ip, req_dst_mac, req_src_mac,
        output req_ready, done, status
    );
endinterface

// File: rtl/endpoint_table_writer.sv
// Write-side manager of the endpoint table BRAM (Port A): read-check-write insert/update/delete
// with collision detection and an optional post-reset clear sweep.
module endpoint_table_writer #(
    parameter int unsigned ADDR_WIDTH      = 4,
    parameter int unsigned BRAM_DATA_WIDTH = 256,
    parameter bit          CLEAR_ON_RESET  = 1'b1
) (
    input  logic                       clk,
    input  logic                       rstn,
    endpoint_table_writer_if.slave     req,
    output logic [ADDR_WIDTH:0]        entry_count,
    output logic                       init_busy,
    output logic [ADDR_WIDTH-1:0]      bram_addr_a,
    output logic                       bram_en_a,
    output logic                       bram_we_a,
    output logic [BRAM_DATA_WIDTH-1:0] bram_din_a,
    input  logic [BRAM_DATA_WIDTH-1:0] bram_dout_a
);
    localparam int unsigned W     = BRAM_DATA_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    localparam logic [CW-1:0]         COUNT_MAX  = CW'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] SWEEP_LAST = '1;

    localparam logic [1:0] ST_OK        = 2'b00;
    localparam logic [1:0] ST_UPDATED   = 2'b01;
    localparam logic [1:0] ST_COLLISION = 2'b10;
    localparam logic [1:0] ST_NOT_FOUND = 2'b11;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_RD,
        S_CMP,
        S_WR,
        S_RSP
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] sweep_q, sweep_d;
    logic                  op_q, op_d;
    logic [31:0]           ip_q, ip_d;
    logic [47:0]           dmac_q, dmac_d;
    logic [47:0]           smac_q, smac_d;

    logic                  ready_q, ready_d;
    logic                  done_q, done_d;
    logic [1:0]            status_q, status_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  busy_q, busy_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  en_q, en_d;
    logic                  we_q, we_d;
    logic [W-1:0]          din_q, din_d;

    logic                  occ_c;
    logic                  match_c;
    logic                  unused_dout;

    // Same entry layout as endpoint_lookup: valid, dst_ip, dst_mac, src_mac from the MSB down.
    function automatic logic [W-1:0] pack_entry(input logic [31:0] ip,
                                                input logic [47:0] dmac,
                                                input logic [47:0] smac);
        logic [W-1:0] e;
        e              = '0;
        e[W-1]         = 1'b1;
        e[W-33 -: 32]  = ip;
        e[W-65 -: 48]  = dmac;
        e[W-113 -: 48] = smac;
        return e;
    endfunction

    assign occ_c       = bram_dout_a[W-1];
    assign match_c     = occ_c && (bram_dout_a[W-33 -: 32] == ip_q);
    assign unused_dout = ^{bram_dout_a[W-2 -: 31], bram_dout_a[W-65:0]};

    assign req.req_ready = ready_q;
    assign req.done      = done_q;
    assign req.status    = status_q;
    assign entry_count   = count_q;
    assign init_busy     = busy_q;
    assign bram_addr_a   = addr_q;
    assign bram_en_a     = en_q;
    assign bram_we_a     = we_q;
    assign bram_din_a    = din_q;

    // State and registered outputs; reset aborts any operation and reruns INIT.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_INIT;
            sweep_q  <= '0;
            op_q     <= 1'b0;
            ip_q     <= '0;
            dmac_q   <= '0;
            smac_q   <= '0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            status_q <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            addr_q   <= '0;
            en_q     <= 1'b0;
            we_q     <= 1'b0;
            din_q    <= '0;
        end else begin
            state_q  <= state_d;
            sweep_q  <= sweep_d;
            op_q     <= op_d;
            ip_q     <= ip_d;
            dmac_q   <= dmac_d;
            smac_q   <= smac_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            status_q <= status_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            addr_q   <= addr_d;
            en_q     <= en_d;
            we_q     <= we_d;
            din_q    <= din_d;
        end
    end

    // Next state; output values are computed one cycle ahead so they appear with the state they belong to.
    always_comb begin
        state_d  = state_q;
        sweep_d  = sweep_q;
        op_d     = op_q;
        ip_d     = ip_q;
        dmac_d   = dmac_q;
        smac_d   = smac_q;
        ready_d  = 1'b0;
        done_d   = 1'b0;
        status_d = status_q;
        count_d  = count_q;
        busy_d   = 1'b0;
        addr_d   = addr_q;
        en_d     = 1'b0;
        we_d     = 1'b0;
        din_d    = din_q;

        case (state_q)
            S_INIT: begin
                if (CLEAR_ON_RESET) begin
                    en_d    = 1'b1;
                    we_d    = 1'b1;
                    busy_d  = 1'b1;
                    addr_d  = sweep_q;
                    din_d   = '0;
                    sweep_d = sweep_q + ADDR_WIDTH'(1);
                    if (sweep_q == SWEEP_LAST) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_IDLE: begin
                ready_d = 1'b1;
                if (req.req_valid && ready_q) begin
                    op_d    = req.req_op;
                    ip_d    = req.req_ip;
                    dmac_d  = req.req_dst_mac;
                    smac_d  = req.req_src_mac;
                    ready_d = 1'b0;
                    en_d    = 1'b1;
                    addr_d  = req.req_ip[ADDR_WIDTH-1:0];
                    state_d = S_RD;
                end
            end

            S_RD: begin
                state_d = S_CMP;
            end

            S_CMP: begin
                addr_d  = ip_q[ADDR_WIDTH-1:0];
                state_d = S_WR;
                if (!op_q) begin
                    din_d = pack_entry(ip_q, dmac_q, smac_q);
                    if (!occ_c) begin
                        en_d     = 1'b1;
                        we_d     = 1'b1;
                        status_d = ST_OK;
                        if (count_q != COUNT_MAX) begin
                            count_d = count_q + CW'(1);
                        end
                    end else if (match_c) begin
                        en_d     = 1'b1;
                        we_d     = 1'b1;
                        status_d = ST_UPDATED;
                    end else begin
                        status_d = ST_COLLISION;
                    end
                end else begin
                    din_d = '0;
                    if (match_c) begin
                        en_d     = 1'b1;
                        we_d     = 1'b1;
                        status_d = ST_OK;
                        if (count_q != '0) begin
                            count_d = count_q - CW'(1);
                        end
                    end else begin
                        status_d = ST_NOT_FOUND;
                    end
                end
            end

            S_WR: begin
                done_d  = 1'b1;
                state_d = S_RSP;
            end

            S_RSP: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_INIT;
            end
        endcase
    end
endmodule

// File: tb/tb_endpoint_table_writer.sv
// Directed self-checking bench for endpoint_table_writer with a behavioural Port A BRAM.
module tb_endpoint_table_writer;
    localparam int unsigned AW = 4;
    localparam int unsigned W  = 256;

    localparam logic [W-1:0] EXP_ENTRY1 =
        256'h8000_0000_C0A8_010A_1122_3344_5566_0000_0000_0000_0000_0000_0000_0000_0000_0000;
    localparam logic [W-1:0] EXP_ENTRY2 =
        256'h8000_0000_C0A8_010A_AABB_CCDD_EEFF_0000_0000_0000_0000_0000_0000_0000_0000_0000;

    logic clk  = 1'b0;
    logic rstn = 1'b1;

    endpoint_table_writer_if ifc ();

    logic [AW:0]   entry_count;
    logic          init_busy;
    logic [AW-1:0] bram_addr_a;
    logic          bram_en_a;
    logic          bram_we_a;
    logic [W-1:0]  bram_din_a;
    logic [W-1:0]  bram_dout_a;

    logic [W-1:0]  mem [0:(1<<AW)-1];
    int            wr_cnt = 0;
    logic [AW-1:0] last_wr_addr;
    logic [W-1:0]  last_wr_din;

    int checks   = 0;
    int failures = 0;

    endpoint_table_writer #(
        .ADDR_WIDTH     (AW),
        .BRAM_DATA_WIDTH(W),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req        (ifc),
        .entry_count(entry_count),
        .init_busy  (init_busy),
        .bram_addr_a(bram_addr_a),
        .bram_en_a  (bram_en_a),
        .bram_we_a  (bram_we_a),
        .bram_din_a (bram_din_a),
        .bram_dout_a(bram_dout_a)
    );

    always #5 clk = ~clk;

    // Port A BRAM: synchronous read, write-only cycles do not update dout.
    always @(posedge clk) begin
        if (bram_en_a) begin
            if (bram_we_a) begin
                mem[bram_addr_a] <= bram_din_a;
                wr_cnt           <= wr_cnt + 1;
                last_wr_addr     <= bram_addr_a;
                last_wr_din      <= bram_din_a;
            end else begin
                bram_dout_a <= mem[bram_addr_a];
            end
        end
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the RD cycle (one cycle after the handshake).
    task automatic start_req(input logic op, input logic [31:0] ip,
                             input logic [47:0] dm, input logic [47:0] sm, output bit ok);
        ifc.req_op      = op;
        ifc.req_ip      = ip;
        ifc.req_dst_mac = dm;
        ifc.req_src_mac = sm;
        ifc.req_valid   = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (ifc.req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_req(input string tag, input logic op, input logic [31:0] ip,
                          input logic [47:0] dm, input logic [47:0] sm,
                          output logic [1:0] st, output int lat, output logic [AW:0] cnt);
        bit ok;
        lat = -1;
        st  = 2'b00;
        cnt = '0;
        start_req(op, ip, dm, sm, ok);
        check({tag, "_handshake"}, W'(ok), W'(1));
        ifc.req_valid = 1'b0;
        if (ok) begin
            for (int n = 1; n <= 20; n++) begin
                if (ifc.done) begin
                    lat = n;
                    st  = ifc.status;
                    cnt = entry_count;
                    break;
                end
                @(negedge clk);
            end
        end
    endtask

    // Follows the clear sweep from reset release until req_ready rises.
    task automatic sweep_check(input string tag);
        int nwr      = 0;
        bit order_ok = 1'b1;
        bit zero_ok  = 1'b1;
        bit busy_ok  = 1'b1;
        bit reached  = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (ifc.req_ready) begin
                reached = 1'b1;
                break;
            end
            if (bram_en_a && bram_we_a) begin
                if (bram_addr_a != AW'(nwr)) order_ok = 1'b0;
                if (bram_din_a != '0) zero_ok = 1'b0;
                if (!init_busy) busy_ok = 1'b0;
                nwr++;
            end
            @(negedge clk);
        end
        check({tag, "_ready_rise"}, W'(reached), W'(1));
        check({tag, "_sweep_writes"}, W'(nwr), W'(16));
        check({tag, "_sweep_order"}, W'(order_ok), W'(1));
        check({tag, "_sweep_zero"}, W'(zero_ok), W'(1));
        check({tag, "_sweep_busy"}, W'(busy_ok), W'(1));
        check({tag, "_busy_after"}, W'(init_busy), W'(0));
        check({tag, "_count_after"}, W'(entry_count), W'(0));
    endtask

    initial begin
        logic [1:0]  st;
        int          lat;
        logic [AW:0] cnt;
        int          w0;
        bit          ok;
        logic [W-1:0] word;
        logic         hit;

        ifc.req_valid   = 1'b0;
        ifc.req_op      = 1'b0;
        ifc.req_ip      = '0;
        ifc.req_dst_mac = '0;
        ifc.req_src_mac = '0;

        #2 rstn = 1'b0;
        #1;
        check("rst_ctrl", W'({ifc.req_ready, ifc.done, ifc.status, init_busy, bram_en_a, bram_we_a}), W'(0));
        check("rst_count", W'(entry_count), W'(0));
        check("rst_bus", W'({bram_addr_a, bram_din_a}), W'(0));
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        sweep_check("init");

        w0 = wr_cnt;
        do_req("ins_new", 1'b0, 32'hC0A8010A, 48'h112233445566, 48'h0, st, lat, cnt);
        check("ins_new_status", W'(st), W'(2'b00));
        check("ins_new_latency", W'(lat), W'(4));
        check("ins_new_count", W'(cnt), W'(1));
        check("ins_new_nwrites", W'(wr_cnt - w0), W'(1));
        check("ins_new_addr", W'(last_wr_addr), W'(10));
        check("ins_new_word", last_wr_din, EXP_ENTRY1);

        w0 = wr_cnt;
        do_req("ins_upd", 1'b0, 32'hC0A8010A, 48'hAABBCCDDEEFF, 48'h0, st, lat, cnt);
        check("ins_upd_status", W'(st), W'(2'b01));
        check("ins_upd_count", W'(cnt), W'(1));
        check("ins_upd_nwrites", W'(wr_cnt - w0), W'(1));
        check("ins_upd_mem10", mem[10], EXP_ENTRY2);

        w0 = wr_cnt;
        do_req("ins_coll", 1'b0, 32'hC0A8011A, 48'h010203040506, 48'h0A0B0C0D0E0F, st, lat, cnt);
        check("ins_coll_status", W'(st), W'(2'b10));
        check("ins_coll_nwrites", W'(wr_cnt - w0), W'(0));
        check("ins_coll_mem10", mem[10], EXP_ENTRY2);
        check("ins_coll_count", W'(cnt), W'(1));

        w0 = wr_cnt;
        do_req("del_empty", 1'b1, 32'h0A000001, 48'h0, 48'h0, st, lat, cnt);
        check("del_empty_status", W'(st), W'(2'b11));
        check("del_empty_nwrites", W'(wr_cnt - w0), W'(0));
        check("del_empty_count", W'(cnt), W'(1));

        w0 = wr_cnt;
        do_req("del_hit", 1'b1, 32'hC0A8010A, 48'h0, 48'h0, st, lat, cnt);
        check("del_hit_status", W'(st), W'(2'b00));
        check("del_hit_latency", W'(lat), W'(4));
        check("del_hit_count", W'(cnt), W'(0));
        check("del_hit_nwrites", W'(wr_cnt - w0), W'(1));
        check("del_hit_addr", W'(last_wr_addr), W'(10));
        check("del_hit_mem10", mem[10], W'(0));
        word = mem[10];
        hit  = word[W-1] && (word[W-33 -: 32] == 32'hC0A8010A);
        check("lookup_after_delete", W'(hit), W'(0));

        // Abort an insert in its WR cycle with req_valid held high through reset.
        @(negedge clk);
        start_req(1'b0, 32'hC0A8010A, 48'h112233445566, 48'h0, ok);
        check("abort_handshake", W'(ok), W'(1));
        @(negedge clk);
        @(negedge clk);
        check("abort_wr_en_we", W'({bram_en_a, bram_we_a}), W'(2'b11));
        check("abort_wr_count", W'(entry_count), W'(1));
        #1 rstn = 1'b0;
        #1;
        check("abort_en_we_drop", W'({bram_en_a, bram_we_a}), W'(0));
        check("abort_count_clear", W'(entry_count), W'(0));
        @(negedge clk);
        check("abort_ready_low", W'(ifc.req_ready), W'(0));
        rstn = 1'b1;
        sweep_check("reinit");

        do_req("post_rst", 1'b0, 32'hC0A8010A, 48'h112233445566, 48'h0, st, lat, cnt);
        check("post_rst_status", W'(st), W'(2'b00));
        check("post_rst_latency", W'(lat), W'(4));
        check("post_rst_count", W'(cnt), W'(1));
        check("post_rst_mem10", mem[10], EXP_ENTRY1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
